scarv_cop_ififo: RTL and testbench
==================================

Name: scarv_cop_ififo

Overview:
- Instruction buffer directly upstream of the COP instruction decoder.
- Accepts 32-bit encoded ISE instructions from the host CPU over a req/ack handshake and holds them in a small in-order FIFO.
- Presents the oldest entry as id_encoded to the decoder, with a valid/ready handshake to the COP execute stage.
- Provides flush on host pipeline kill, an occupancy count, and a retired-instruction counter.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- g_clk  input  1  core clock; all state updates on rising edge.
- g_reset  input  1  synchronous, active-high reset.
- cpu_insn_req  input  1  host offers an instruction.
- cpu_insn_ack  output  1  COP accepts the offered instruction this cycle.
- cpu_insn_enc  input  32  encoded instruction word from host.
- cop_flush  input  1  discard all buffered instructions.
- id_valid  output  1  id_encoded holds a valid instruction.
- id_ready  input  1  execute stage consumes id_encoded this cycle.
- id_encoded  output  32  oldest buffered instruction; feeds the decoder.
- fifo_count  output  PTR_W+1  current occupancy, 0..DEPTH.
- insn_retired  output  32  count of instructions popped since reset.
- cop_idle  output  1  high when the FIFO is empty and no flush is in progress.

Behaviour:
- Reset (g_reset=1 at a clock edge): rd_ptr=0, wr_ptr=0, count=0, insn_retired=0.
  - id_valid=0, cpu_insn_ack=0 during reset, id_encoded=0, cop_idle=1.
  - Storage contents need no reset.
  - Reset mid-transfer drops every entry; no ack is issued in the reset cycle.
- Push: push = cpu_insn_req && cpu_insn_ack.
  - cpu_insn_ack = !g_reset && !cop_flush && (count != DEPTH). Purely a function of state and these two inputs.
  - No full-plus-pop pass-through, so ack has no combinational path from id_ready.
  - On push, mem[wr_ptr] <= cpu_insn_enc and wr_ptr <= wr_ptr+1. Wraps modulo DEPTH.
- Pop: pop = id_valid && id_ready.
  - id_valid = (count != 0) && !cop_flush.
  - id_encoded = mem[rd_ptr] when id_valid, else 32'h0. Zero-gating keeps the decoder input quiet.
  - On pop, rd_ptr <= rd_ptr+1 (wraps) and insn_retired <= insn_retired+1 (wraps 2^32-1 → 0).
- Count update:
  - push only: +1; pop only: −1; push and pop together: unchanged, both pointers advance.
- Full (count=DEPTH): ack=0; a pop that cycle frees one slot, so ack goes high the next cycle.
- Empty (count=0): id_valid=0; an instruction pushed at edge N is presented from cycle N+1 (1-cycle latency).
- Flush: cop_flush=1 at an edge sets rd_ptr=wr_ptr=0 and count=0.
  - Ack and valid are forced low in the flush cycle, so neither push nor pop can coincide with it.
  - insn_retired is not cleared.
  - Flush held over several cycles keeps the FIFO empty.
- Priority: g_reset > cop_flush > push/pop.
- Assertions (simulation only):
  - No push when count=DEPTH.
  - No pop when count=0.
  - count == (wr_ptr − rd_ptr) mod DEPTH, with full disambiguated by count.
- cop_idle = (count==0) && !cop_flush.

Optional Feature:
- SCARV_COP_IFIFO_BYPASS_EN defined: when count==0 and cpu_insn_req=1 and no flush, the input passes combinationally to the output.
  - id_valid=1 and id_encoded=cpu_insn_enc in the same cycle.
  - If id_ready=1, that cycle counts as both push and pop: count and pointers unchanged, insn_retired+1, nothing is written.
  - If id_ready=0, the word is pushed normally.
  - Zero-latency issue from empty.
- Undefined: no bypass; strict 1-cycle minimum latency as above.

Test Plan:
- Reset then idle → after reset: id_valid=0, cpu_insn_ack=1, fifo_count=0, insn_retired=0, cop_idle=1, id_encoded=0.
- Push 0x0000_1A2B with id_ready=0 → next cycle: id_valid=1, id_encoded=0x0000_1A2B, fifo_count=1. Then id_ready=1 for one cycle → fifo_count=0, insn_retired=1.
- Push 4 words 0x11,0x22,0x33,0x44 with id_ready=0 → fifo_count=4, ack=0. A 5th req is held unacked. Then pop each cycle → outputs appear in order 0x11..0x44, and ack=1 one cycle after the first pop.
- Sustained push+pop every cycle for 10 cycles from count=2 → fifo_count stays 2, pointers wrap twice, output order matches input order, insn_retired=+10.
- Fill 3 entries then assert cop_flush with cpu_insn_req=1 → in flush cycle ack=0 and id_valid=0. Next cycle fifo_count=0, insn_retired unchanged, and the held req is accepted.
- Preload insn_retired to 0xFFFF_FFFF via 2^32−1 pops (or force in bench), then one pop → insn_retired=0. With SCARV_COP_IFIFO_BYPASS_EN: from empty, req with id_ready=1 → id_valid same cycle, fifo_count stays 0.

Source files
------------

// File: rtl/scarv_cop_ififo.sv
// scarv_cop_ififo: in-order instruction buffer feeding the COP decoder.
//   Accepts 32-bit encoded ISE instructions from the host over req/ack and
//   presents the oldest buffered word to the decoder over valid/ready.
//
// Ports:
//   g_clk         core clock, all state updates on the rising edge
//   g_reset       synchronous active-high reset
//   cpu_insn_req  host offers cpu_insn_enc
//   cpu_insn_ack  buffer accepts the offered word this cycle
//   cpu_insn_enc  encoded instruction word from the host
//   cop_flush     discard all buffered instructions
//   id_valid      id_encoded holds a valid instruction
//   id_ready      execute stage consumes id_encoded this cycle
//   id_encoded    oldest buffered instruction (zero when not valid)
//   fifo_count    current occupancy, 0..DEPTH
//   insn_retired  instructions popped since reset (wraps)
//   cop_idle      buffer empty and no flush in progress
//
// Optional feature: define SCARV_COP_IFIFO_BYPASS_EN to pass an offered
// word straight through to the decoder when the buffer is empty.

module scarv_cop_ififo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             cpu_insn_req,
  output logic             cpu_insn_ack,
  input  logic [31:0]      cpu_insn_enc,
  input  logic             cop_flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_encoded,
  output logic [PTR_W:0]   fifo_count,
  output logic [31:0]      insn_retired,
  output logic             cop_idle
);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      retired_q, retired_d;

  logic not_empty, full, bypass, byp_take, push, pop, wr_en, rd_adv;

  // Handshakes, presentation and next-state.
  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == (PTR_W+1)'(DEPTH));

`ifdef SCARV_COP_IFIFO_BYPASS_EN
    bypass = !not_empty && cpu_insn_req && !cop_flush && !g_reset;
`else
    bypass = 1'b0;
`endif

    // ack never depends on id_ready: no full-plus-pop pass-through.
    cpu_insn_ack = !g_reset && !cop_flush && !full;
    id_valid     = (not_empty && !cop_flush && !g_reset) || bypass;

    if (not_empty && !cop_flush && !g_reset) id_encoded = mem_q[rd_ptr_q];
    else if (bypass)                         id_encoded = cpu_insn_enc;
    else                                     id_encoded = 32'h0;

    push     = cpu_insn_req && cpu_insn_ack;
    pop      = id_valid && id_ready;
    // A bypassed word consumed in the same cycle never touches storage.
    byp_take = bypass && id_ready;
    wr_en    = push && !byp_take;
    rd_adv   = pop && !byp_take;

    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    retired_d = retired_q + (pop ? 32'd1 : 32'd0);

    if (cop_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end

    fifo_count   = count_q;
    insn_retired = retired_q;
    cop_idle     = !not_empty && !cop_flush;
  end

  // Pointer, occupancy and retire counter state.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      retired_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      retired_q <= retired_d;
    end
  end

  // Storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge g_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= cpu_insn_enc;
  end

  // Occupancy / pointer consistency checks.
  always @(posedge g_clk) begin
    if (!g_reset) begin
      assert (!(push && full))
        else $error("ififo: push while full");
      assert (!(pop && !not_empty && !bypass))
        else $error("ififo: pop while empty");
      assert (count_q <= (PTR_W+1)'(DEPTH))
        else $error("ififo: count out of range");
      assert (count_q[PTR_W-1:0] == PTR_W'(wr_ptr_q - rd_ptr_q))
        else $error("ififo: count disagrees with pointers");
    end
  end

endmodule

// File: tb/tb_scarv_cop_ififo.sv
// Directed self-checking bench for scarv_cop_ififo.
module tb_scarv_cop_ififo;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        cpu_insn_req;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic        cop_flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_encoded;
  logic [2:0]  fifo_count;
  logic [31:0] insn_retired;
  logic        cop_idle;

  int n_tests = 0;
  int n_fail  = 0;

  scarv_cop_ififo #(.DEPTH(4), .PTR_W(2)) dut (
    .g_clk        (g_clk),
    .g_reset      (g_reset),
    .cpu_insn_req (cpu_insn_req),
    .cpu_insn_ack (cpu_insn_ack),
    .cpu_insn_enc (cpu_insn_enc),
    .cop_flush    (cop_flush),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_encoded   (id_encoded),
    .fifo_count   (fifo_count),
    .insn_retired (insn_retired),
    .cop_idle     (cop_idle)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    g_reset = 1'b1; cpu_insn_req = 1'b0; cpu_insn_enc = '0;
    cop_flush = 1'b0; id_ready = 1'b0;
    tick(); #1;
    chk("rst_ack", 32'(cpu_insn_ack), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    tick();
    g_reset = 1'b0; #1;
    chk("idle_valid", 32'(id_valid), 32'd0);
    chk("idle_ack", 32'(cpu_insn_ack), 32'd1);
    chk("idle_count", 32'(fifo_count), 32'd0);
    chk("idle_retired", insn_retired, 32'd0);
    chk("idle_cop_idle", 32'(cop_idle), 32'd1);
    chk("idle_enc", id_encoded, 32'd0);

    // Single push then pop.
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0000_1A2B; #1;
`ifndef SCARV_COP_IFIFO_BYPASS_EN
    chk("lat_valid_same_cycle", 32'(id_valid), 32'd0);
`endif
    tick();
    cpu_insn_req = 1'b0; #1;
    chk("one_valid", 32'(id_valid), 32'd1);
    chk("one_enc", id_encoded, 32'h0000_1A2B);
    chk("one_count", 32'(fifo_count), 32'd1);
    chk("one_cop_idle", 32'(cop_idle), 32'd0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0; #1;
    chk("one_pop_count", 32'(fifo_count), 32'd0);
    chk("one_pop_retired", insn_retired, 32'd1);
    chk("one_pop_valid", 32'(id_valid), 32'd0);

    // Fill to full, hold a 5th request, then drain.
    for (int i = 0; i < 4; i++) begin
      cpu_insn_req = 1'b1; cpu_insn_enc = 32'(i + 1) * 32'h11;
      tick();
    end
    cpu_insn_enc = 32'h55; #1;
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ack", 32'(cpu_insn_ack), 32'd0);
    tick(); #1;
    chk("full_held_count", 32'(fifo_count), 32'd4);
    chk("full_held_enc", id_encoded, 32'h11);
    id_ready = 1'b1; #1;
    chk("drain0_ack", 32'(cpu_insn_ack), 32'd0);
    chk("drain0_enc", id_encoded, 32'h11);
    tick(); #1;
    chk("drain1_ack", 32'(cpu_insn_ack), 32'd1);
    chk("drain1_enc", id_encoded, 32'h22);
    tick();
    cpu_insn_req = 1'b0; #1;
    chk("drain2_count", 32'(fifo_count), 32'd3);
    chk("drain2_enc", id_encoded, 32'h33);
    tick(); #1;
    chk("drain3_enc", id_encoded, 32'h44);
    tick(); #1;
    chk("drain4_enc", id_encoded, 32'h55);
    tick();
    id_ready = 1'b0; #1;
    chk("drain_count", 32'(fifo_count), 32'd0);
    chk("drain_retired", insn_retired, 32'd6);

    // Sustained push+pop at occupancy 2.
    cpu_insn_req = 1'b1;
    cpu_insn_enc = 32'hA0; tick();
    cpu_insn_enc = 32'hA1; tick();
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_insn_enc = 32'hA2 + 32'(i); #1;
      chk($sformatf("stream%0d_enc", i), id_encoded, 32'hA0 + 32'(i));
      chk($sformatf("stream%0d_count", i), 32'(fifo_count), 32'd2);
      tick();
    end
    cpu_insn_req = 1'b0; id_ready = 1'b0; #1;
    chk("stream_count", 32'(fifo_count), 32'd2);
    chk("stream_retired", insn_retired, 32'd16);
    chk("stream_next_enc", id_encoded, 32'hAA);
    id_ready = 1'b1;
    tick(); tick();
    id_ready = 1'b0; #1;
    chk("stream_drain_count", 32'(fifo_count), 32'd0);
    chk("stream_drain_retired", insn_retired, 32'd18);

    // Flush with a pending request.
    cpu_insn_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_insn_enc = 32'hB0 + 32'(i); tick();
    end
    cop_flush = 1'b1; cpu_insn_enc = 32'hC0; #1;
    chk("flush_ack", 32'(cpu_insn_ack), 32'd0);
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_enc", id_encoded, 32'd0);
    chk("flush_cop_idle", 32'(cop_idle), 32'd0);
    tick();
    cop_flush = 1'b0; #1;
    chk("postflush_count", 32'(fifo_count), 32'd0);
    chk("postflush_retired", insn_retired, 32'd18);
    chk("postflush_ack", 32'(cpu_insn_ack), 32'd1);
    chk("postflush_cop_idle", 32'(cop_idle), 32'd1);
    tick();
    cpu_insn_req = 1'b0; #1;
    chk("postflush_push_count", 32'(fifo_count), 32'd1);
    chk("postflush_push_enc", id_encoded, 32'hC0);
    cop_flush = 1'b1;
    tick(); tick();
    cop_flush = 1'b0; #1;
    chk("longflush_count", 32'(fifo_count), 32'd0);

    // Retire counter wrap.
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'hD0;
    tick();
    cpu_insn_req = 1'b0;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    #1;
    chk("wrap_pre", insn_retired, 32'hFFFF_FFFF);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0; #1;
    chk("wrap_post", insn_retired, 32'd0);
    chk("wrap_count", 32'(fifo_count), 32'd0);

`ifdef SCARV_COP_IFIFO_BYPASS_EN
    // Zero-latency issue from empty.
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'hE0; id_ready = 1'b1; #1;
    chk("byp_valid", 32'(id_valid), 32'd1);
    chk("byp_enc", id_encoded, 32'hE0);
    tick();
    cpu_insn_req = 1'b0; id_ready = 1'b0; #1;
    chk("byp_count", 32'(fifo_count), 32'd0);
    chk("byp_retired", insn_retired, 32'd1);
`endif

    // Reset mid-transfer drops everything.
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'hF0; tick();
    cpu_insn_enc = 32'hF1; tick();
    g_reset = 1'b1; #1;
    chk("midrst_ack", 32'(cpu_insn_ack), 32'd0);
    chk("midrst_enc", id_encoded, 32'd0);
    tick();
    g_reset = 1'b0; cpu_insn_req = 1'b0; #1;
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_retired", insn_retired, 32'd0);
    chk("midrst_valid", 32'(id_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
